btb_assoc: RTL and testbench
============================

// Module: btb_assoc
// PURPOSE
//   Parametrised, set-associative branch target buffer with a direction predictor.
//   Serves two same-cycle fetch lookups (slots A and B) and one resolve-stage update port.
//   Each entry holds a full tag, a target, a valid bit and a saturating direction counter.
//   Per-set victim pointers choose replacement; a multi-cycle flush engine clears all entries.
// PARAMETERS
//   PC_W      16    width of PCs and targets; bit 0 is always ignored
//   SETS      64    number of sets; power of 2, >=2; IDX_W = log2(SETS)
//   WAYS      2     ways per set; power of 2, 1..8
//   CTR_W     2     direction counter width
//   CTR_INIT  2     counter value written on allocation; must be >= 2^(CTR_W-1) (taken half)
// PORTS
//   clk         in   1     clock; all state changes on the rising edge
//   rst_n       in   1     reset; asynchronous assert, active-low
//   pc_a        in   PC_W  lookup PC, slot A
//   hit_a       out  1     slot A tag hit
//   taken_a     out  1     slot A predicted taken
//   target_a    out  PC_W  slot A next-fetch PC
//   pc_b        in   PC_W  lookup PC, slot B
//   hit_b       out  1     slot B tag hit
//   taken_b     out  1     slot B predicted taken
//   target_b    out  PC_W  slot B next-fetch PC
//   upd_valid   in   1     resolved-branch update strobe
//   upd_pc      in   PC_W  PC of the resolved branch
//   upd_taken   in   1     resolved direction
//   upd_target  in   PC_W  resolved target
//   flush_req   in   1     start a full invalidation
//   flush_busy  out  1     flush engine active
// BEHAVIOUR
//   Address split: idx = pc[IDX_W:1]; tag = pc[PC_W-1:IDX_W+1]. This is the full tag, with no aliasing.
//   Lookup is combinational, with zero latency, and the two slots are independent.
//     Each slot uses its own PC for both index and tag.
//     hit_x = any way in set idx_x that is valid and whose tag equals tag_x.
//     Exactly one way can match, because allocation never duplicates a tag.
//     taken_x = hit_x & ctr[CTR_W-1].
//     target_x = taken_x ? stored target : pc_x + 2, truncated mod 2^PC_W (wraps at the top).
//   Update, sampled at posedge when upd_valid=1 and the FSM is IDLE:
//     On a hit in way w:
//       - ctr increments, saturating at 2^CTR_W-1, if upd_taken; otherwise it decrements, saturating at 0.
//       - If upd_taken, the stored target is replaced by upd_target.
//     On a miss with upd_taken=1, allocate in set idx:
//       - Victim is the lowest-numbered invalid way; if all ways are valid, the way at victim_ptr[idx].
//       - Write tag, target and valid=1; set ctr=CTR_INIT.
//       - victim_ptr[idx] advances by 1 mod WAYS only when a valid way was evicted.
//     On a miss with upd_taken=0: no state change.
//   Read-during-write: lookups in the same cycle see pre-update contents, with no bypass.
//   Flush FSM, states IDLE and FLUSH:
//     IDLE -> FLUSH on flush_req; the set counter fcnt is loaded with 0.
//     In FLUSH, each cycle clears valid in all ways of set fcnt and clears victim_ptr[fcnt], then fcnt++.
//     When fcnt == SETS-1, that set is cleared and the FSM returns to IDLE.
//     Total flush time is SETS cycles.
//     flush_busy = (state == FLUSH), driven from a register.
//     During FLUSH: hit_x=0, taken_x=0, target_x=pc_x+2; upd_valid is dropped; flush_req is ignored.
//     If flush_req and upd_valid arrive in the same IDLE cycle, the flush wins and the update is dropped.
//   Reset (asynchronous, rst_n=0):
//     - All valid bits, counters, victim pointers and fcnt are cleared to 0; FSM goes to IDLE.
//     - flush_busy=0, hit_x=0, taken_x=0, target_x=pc_x+2.
//     - Reset during FLUSH aborts the flush; the array is already fully invalid.
//   Tag and target storage need no reset; valid gates every use of them.
// TESTING
//   1. Reset, then pc_a=0x0100 and pc_b=0x0102 -> hit=0, taken=0, target_a=0x0102, target_b=0x0104.
//   2. upd 0x0100 taken -> 0x0400; next cycle pc_a=0x0100 -> hit=1, taken=1, target=0x0400.
//      Two not-taken updates -> ctr=0, hit=1, taken=0, target=0x0102.
//   3. WAYS=2 set conflict: allocate 0x0100, 0x8100, then 0xC100 -> 0x0100 evicted (ptr 0).
//      Then 0x4100 -> 0x8100 evicted; both survivors hit.
//   4. Same-cycle upd and lookup of a new branch -> that cycle misses, next cycle hits.
//      pc=0xFFFE on a miss -> target=0x0000.
//   5. flush_req -> flush_busy high for exactly SETS cycles, lookups miss, upd during busy dropped.
//      After flush all prior entries miss.
//   6. Assert rst_n=0 mid-flush with no clock edge -> flush_busy=0 and hits=0 immediately.
//      Operation resumes normally after release.

Source files
------------

// File: rtl/btb_assoc.sv
// -----------------------------------------------------------------------------
// btb_assoc
//   Set-associative branch target buffer with a saturating-counter direction
//   predictor. Two independent combinational fetch lookups (slots A and B) see
//   the array as it stood before the current clock edge. A resolve-stage update
//   port trains counters, refreshes targets and allocates taken branches.
//   A flush engine invalidates one set per cycle, so a full flush takes SETS
//   cycles.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   pc_a / pc_b                 lookup PCs for slots A and B
//   hit_x, taken_x, target_x    per-slot prediction (target is pc_x+2 unless
//                               the slot is predicted taken)
//   upd_valid, upd_pc,
//   upd_taken, upd_target       resolved-branch update
//   flush_req                   start a full invalidation
//   flush_busy                  flush engine active
// -----------------------------------------------------------------------------
module btb_assoc #(
    parameter int PC_W     = 16,
    parameter int SETS     = 64,
    parameter int WAYS     = 2,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc_a,
    output logic            hit_a,
    output logic            taken_a,
    output logic [PC_W-1:0] target_a,
    input  logic [PC_W-1:0] pc_b,
    output logic            hit_b,
    output logic            taken_b,
    output logic [PC_W-1:0] target_b,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush_req,
    output logic            flush_busy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_W - 1 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic            hit;
        logic            taken;
        logic [PC_W-1:0] target;
    } lookup_t;

    // Array state
    logic [SETS-1:0][WAYS-1:0]            valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0][CTR_W-1:0] ctr_q, ctr_d;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0][PC_W-1:0]  target_q, target_d;
    logic [SETS-1:0][WAY_W-1:0]           vptr_q, vptr_d;

    // Flush engine
    state_t           state_q, state_d;
    logic [IDX_W-1:0] fcnt_q, fcnt_d;

    // Bit 0 of the update PC carries no information (instructions are 2-byte aligned).
    logic unused_upd_pc0;
    assign unused_upd_pc0 = upd_pc[0];

    // -------------------------------------------------------------------------
    // Lookup: reads only registered state, so a same-cycle update is invisible.
    // Allocation never duplicates a tag, so at most one way matches.
    // -------------------------------------------------------------------------
    function automatic lookup_t lookup(input logic [PC_W-1:0] pc);
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        lookup_t          r;
        idx      = pc[IDX_W:1];
        tag      = pc[PC_W-1:IDX_W+1];
        r.hit    = 1'b0;
        r.taken  = 1'b0;
        r.target = pc + PC_W'(2);
        if (state_q == S_IDLE) begin
            for (int w = 0; w < WAYS; w++) begin
                if (valid_q[idx][WAY_W'(w)] && (tag_q[idx][WAY_W'(w)] == tag)) begin
                    r.hit = 1'b1;
                    if (ctr_q[idx][WAY_W'(w)][CTR_W-1]) begin
                        r.taken  = 1'b1;
                        r.target = target_q[idx][WAY_W'(w)];
                    end
                end
            end
        end
        return r;
    endfunction

    lookup_t look_a, look_b;

    always_comb begin
        look_a   = lookup(pc_a);
        look_b   = lookup(pc_b);
        hit_a    = look_a.hit;
        taken_a  = look_a.taken;
        target_a = look_a.target;
        hit_b    = look_b.hit;
        taken_b  = look_b.taken;
        target_b = look_b.target;
    end

    // -------------------------------------------------------------------------
    // Flush FSM: state register / next-state / output
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                end
            end
            S_FLUSH: begin
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == IDX_W'(SETS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flush_busy = (state_q == S_FLUSH);
    end

    // -------------------------------------------------------------------------
    // Update / allocate / flush-clear of the array
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [WAY_W-1:0] upd_way;
    logic [WAY_W-1:0] vic_way;
    logic             vic_evict;
    logic             upd_fire;

    always_comb begin
        upd_idx  = upd_pc[IDX_W:1];
        upd_tag  = upd_pc[PC_W-1:IDX_W+1];
        // A flush request in the same IDLE cycle wins over the update.
        upd_fire = upd_valid && (state_q == S_IDLE) && !flush_req;

        upd_hit = 1'b0;
        upd_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[upd_idx][WAY_W'(w)] && (tag_q[upd_idx][WAY_W'(w)] == upd_tag)) begin
                upd_hit = 1'b1;
                upd_way = WAY_W'(w);
            end
        end

        // Lowest-numbered invalid way wins; descending scan leaves the lowest last.
        vic_way   = vptr_q[upd_idx];
        vic_evict = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[upd_idx][WAY_W'(w)]) begin
                vic_way   = WAY_W'(w);
                vic_evict = 1'b0;
            end
        end

        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        vptr_d   = vptr_q;

        if (state_q == S_FLUSH) begin
            valid_d[fcnt_q] = '0;
            vptr_d[fcnt_q]  = '0;
        end else if (upd_fire) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx][upd_way] != '1) begin
                        ctr_d[upd_idx][upd_way] = ctr_q[upd_idx][upd_way] + 1'b1;
                    end
                    target_d[upd_idx][upd_way] = upd_target;
                end else if (ctr_q[upd_idx][upd_way] != '0) begin
                    ctr_d[upd_idx][upd_way] = ctr_q[upd_idx][upd_way] - 1'b1;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx][vic_way]  = 1'b1;
                tag_d[upd_idx][vic_way]    = upd_tag;
                target_d[upd_idx][vic_way] = upd_target;
                ctr_d[upd_idx][vic_way]    = CTR_W'(CTR_INIT);
                // Pointer only moves when it actually chose the victim.
                if (vic_evict) begin
                    vptr_d[upd_idx] = (vptr_q[upd_idx] == WAY_W'(WAYS - 1)) ?
                                      '0 : vptr_q[upd_idx] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ctr_q   <= '0;
            vptr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
            vptr_q  <= vptr_d;
        end
    end

    // NOTE: tag and target storage is deliberately not reset; the valid bit
    // gates every read, and leaving them reset-free keeps them plain RAM-like flops.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_btb_assoc.sv
// -----------------------------------------------------------------------------
// tb_btb_assoc
//   Scoreboarded bench for btb_assoc. The driver applies inputs just after the
//   rising edge and pushes the expected outputs for that cycle; the monitor pops
//   and compares on the falling edge. Expectations come from hand-derived
//   constants (directed part) or a per-set way-table model (random part).
// -----------------------------------------------------------------------------
module tb_btb_assoc;

    localparam int PC_W     = 16;
    localparam int SETS     = 64;
    localparam int WAYS     = 2;
    localparam int CTR_W    = 2;
    localparam int CTR_INIT = 2;
    localparam int IDX_W    = 6;
    localparam int CTR_MAX  = (1 << CTR_W) - 1;
    localparam int CTR_HALF = 1 << (CTR_W - 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PC_W-1:0] pc_a, pc_b;
    logic            hit_a, taken_a, hit_b, taken_b;
    logic [PC_W-1:0] target_a, target_b;
    logic            upd_valid, upd_taken, flush_req, flush_busy;
    logic [PC_W-1:0] upd_pc, upd_target;

    btb_assoc #(
        .PC_W(PC_W), .SETS(SETS), .WAYS(WAYS), .CTR_W(CTR_W), .CTR_INIT(CTR_INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_a(pc_a), .hit_a(hit_a), .taken_a(taken_a), .target_a(target_a),
        .pc_b(pc_b), .hit_b(hit_b), .taken_b(taken_b), .target_b(target_b),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush_req(flush_req), .flush_busy(flush_busy)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [36:0] v;   // {hit_a,taken_a,target_a,hit_b,taken_b,target_b,busy}
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got a={%b,%b,%h} b={%b,%b,%h} busy=%b, want a={%b,%b,%h} b={%b,%b,%h} busy=%b",
                     name, act[36], act[35], act[34:19], act[18], act[17], act[16:1], act[0],
                     exp[36], exp[35], exp[34:19], exp[18], exp[17], exp[16:1], exp[0]);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, {hit_a, taken_a, target_a, hit_b, taken_b, target_b, flush_busy}, e.v);
            end
        end
    end

    // ---------------- reference model ----------------
    bit m_valid [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_tgt   [SETS][WAYS];
    int m_ctr   [SETS][WAYS];
    int m_ptr   [SETS];
    int m_busy;   // remaining flush cycles

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_ctr[s][w]   = 0;
            end
        end
    endtask

    function automatic logic [17:0] predict(input logic [PC_W-1:0] pc);
        int              idx;
        int              tag;
        logic [PC_W-1:0] nxt;
        idx = int'(pc >> 1) % SETS;
        tag = int'(pc >> (IDX_W + 1));
        nxt = pc + 16'd2;
        if (m_busy == 0) begin
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[idx][w] && m_tag[idx][w] == tag) begin
                    if (m_ctr[idx][w] >= CTR_HALF) return {2'b11, m_tgt[idx][w][15:0]};
                    return {2'b10, nxt};
                end
            end
        end
        return {2'b00, nxt};
    endfunction

    // Applies one rising edge to the model, using the inputs currently driven.
    task automatic model_edge();
        int idx, tag, way, hit_w;
        if (!rst_n) begin
            model_clear();
            m_busy = 0;
            return;
        end
        if (m_busy > 0) begin
            m_busy--;
        end else if (flush_req) begin
            // Observable effect of a flush: everything gone once it completes,
            // and nothing visible while it runs.
            model_clear();
            m_busy = SETS;
        end else if (upd_valid) begin
            idx   = int'(upd_pc >> 1) % SETS;
            tag   = int'(upd_pc >> (IDX_W + 1));
            hit_w = -1;
            for (int w = 0; w < WAYS; w++)
                if (m_valid[idx][w] && m_tag[idx][w] == tag) hit_w = w;
            if (hit_w >= 0) begin
                if (upd_taken) begin
                    if (m_ctr[idx][hit_w] < CTR_MAX) m_ctr[idx][hit_w]++;
                    m_tgt[idx][hit_w] = int'(upd_target);
                end else if (m_ctr[idx][hit_w] > 0) begin
                    m_ctr[idx][hit_w]--;
                end
            end else if (upd_taken) begin
                way = -1;
                for (int w = WAYS - 1; w >= 0; w--)
                    if (!m_valid[idx][w]) way = w;
                if (way < 0) begin
                    way        = m_ptr[idx];
                    m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
                end
                m_valid[idx][way] = 1'b1;
                m_tag[idx][way]   = tag;
                m_tgt[idx][way]   = int'(upd_target);
                m_ctr[idx][way]   = CTR_INIT;
            end
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic drive(input logic [15:0] pa, input logic [15:0] pb, input logic uv,
                         input logic [15:0] upc, input logic ut, input logic [15:0] utg,
                         input logic fr);
        pc_a       = pa;
        pc_b       = pb;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utg;
        flush_req  = fr;
    endtask

    task automatic idle(input logic [15:0] pa, input logic [15:0] pb);
        drive(pa, pb, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic expect_const(input string name, input logic [17:0] a,
                                input logic [17:0] b, input logic busy);
        exp_t e;
        e.name = name;
        e.v    = {a, b, busy};
        exp_q.push_back(e);
    endtask

    task automatic expect_model(input string name);
        exp_t e;
        e.name = name;
        e.v    = {predict(pc_a), predict(pc_b), (m_busy > 0)};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [17:0] miss(input logic [15:0] pc);
        return {2'b00, pc + 16'd2};
    endfunction
    function automatic logic [17:0] hit_nt(input logic [15:0] pc);
        return {2'b10, pc + 16'd2};
    endfunction
    function automatic logic [17:0] hit_tk(input logic [15:0] tgt);
        return {2'b11, tgt};
    endfunction

    // ---------------- stimulus ----------------
    initial begin : driver
        logic [15:0] ra, rb, rp;
        m_busy = 0;
        model_clear();
        rst_n = 1'b0;
        idle(16'h0100, 16'h0102);
        @(posedge clk);
        #1;

        // Reset state
        idle(16'h0100, 16'h0102);
        expect_const("reset_outputs", miss(16'h0100), miss(16'h0102), 1'b0);
        tick();
        rst_n = 1'b1;
        expect_const("after_release", 18'h00102, 18'h00104, 1'b0);
        tick();

        // Allocate, read-during-write, counter training
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b1, 16'h0400, 1'b0);
        expect_const("alloc_same_cycle_miss", miss(16'h0100), miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0);
        expect_const("alloc_hit_taken", hit_tk(16'h0400), miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0);
        expect_const("ctr1_not_taken", hit_nt(16'h0100), miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0);
        expect_const("ctr0_not_taken", {2'b10, 16'h0102}, miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b1, 16'h0500, 1'b0);
        expect_const("ctr0_saturated", hit_nt(16'h0100), miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b1, 16'h0500, 1'b0);
        expect_const("ctr1_after_taken", hit_nt(16'h0100), miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b1, 16'h0500, 1'b0);
        expect_const("ctr2_new_target", hit_tk(16'h0500), miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b1, 16'h0500, 1'b0);
        expect_const("ctr3", hit_tk(16'h0500), miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0);
        expect_const("ctr3_saturated", hit_tk(16'h0500), miss(16'h0102), 1'b0);
        tick();
        idle(16'h0100, 16'h0102);
        expect_const("ctr2_still_taken", hit_tk(16'h0500), miss(16'h0102), 1'b0);
        tick();

        // Set conflicts in set 0 (WAYS=2)
        drive(16'h0100, 16'h8100, 1'b1, 16'h8100, 1'b1, 16'h0810, 1'b0);
        expect_const("alloc_8100", hit_tk(16'h0500), miss(16'h8100), 1'b0);
        tick();
        drive(16'h0100, 16'h8100, 1'b1, 16'hC100, 1'b1, 16'h0C10, 1'b0);
        expect_const("alloc_C100", hit_tk(16'h0500), hit_tk(16'h0810), 1'b0);
        tick();
        idle(16'h0100, 16'h8100);
        expect_const("evict_0100", miss(16'h0100), hit_tk(16'h0810), 1'b0);
        tick();
        drive(16'h8100, 16'hC100, 1'b1, 16'h4100, 1'b1, 16'h0410, 1'b0);
        expect_const("alloc_4100", hit_tk(16'h0810), hit_tk(16'h0C10), 1'b0);
        tick();
        idle(16'h8100, 16'hC100);
        expect_const("evict_8100", miss(16'h8100), hit_tk(16'h0C10), 1'b0);
        tick();
        idle(16'h4100, 16'hC100);
        expect_const("survivors_hit", hit_tk(16'h0410), hit_tk(16'h0C10), 1'b0);
        tick();

        // New branch same cycle, PC wrap, not-taken miss does not allocate
        drive(16'h2468, 16'hFFFE, 1'b1, 16'h2468, 1'b1, 16'h1000, 1'b0);
        expect_const("new_branch_miss_wrap", miss(16'h2468), {2'b00, 16'h0000}, 1'b0);
        tick();
        drive(16'h2468, 16'hFFFE, 1'b1, 16'hFFFE, 1'b1, 16'h1234, 1'b0);
        expect_const("new_branch_hit", hit_tk(16'h1000), miss(16'hFFFE), 1'b0);
        tick();
        drive(16'hFFFE, 16'h2468, 1'b1, 16'h3000, 1'b0, 16'hABCD, 1'b0);
        expect_const("top_set_hit", hit_tk(16'h1234), hit_tk(16'h1000), 1'b0);
        tick();
        idle(16'h3000, 16'hFFFE);
        expect_const("nt_miss_no_alloc", miss(16'h3000), hit_tk(16'h1234), 1'b0);
        tick();

        // Flush wins over same-cycle update; busy exactly SETS cycles
        drive(16'h4100, 16'hFFFE, 1'b1, 16'h3002, 1'b1, 16'h7777, 1'b1);
        expect_const("flush_start", hit_tk(16'h0410), hit_tk(16'h1234), 1'b0);
        tick();
        for (int i = 0; i < SETS; i++) begin
            drive(16'h4100, 16'h3002, 1'b1, 16'h3002, 1'b1, 16'h7777, (i % 8) == 3);
            expect_const($sformatf("flush_busy_%0d", i), miss(16'h4100), miss(16'h3002), 1'b1);
            tick();
        end
        idle(16'h4100, 16'h3002);
        expect_const("flush_done", miss(16'h4100), miss(16'h3002), 1'b0);
        tick();
        idle(16'hFFFE, 16'hC100);
        expect_const("flushed_1", miss(16'hFFFE), miss(16'hC100), 1'b0);
        tick();
        idle(16'h2468, 16'h8100);
        expect_const("flushed_2", miss(16'h2468), miss(16'h8100), 1'b0);
        tick();

        // Reset in the middle of a flush
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b1, 16'h0600, 1'b0);
        expect_const("realloc_miss", miss(16'h0100), miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        expect_const("flush2_start", hit_tk(16'h0600), miss(16'h0102), 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            idle(16'h0100, 16'h0102);
            expect_const("flush2_busy", miss(16'h0100), miss(16'h0102), 1'b1);
            tick();
        end
        rst_n = 1'b0;
        expect_const("reset_mid_flush", miss(16'h0100), miss(16'h0102), 1'b0);
        tick();
        rst_n = 1'b1;
        expect_const("resume_idle", miss(16'h0100), miss(16'h0102), 1'b0);
        tick();
        drive(16'h0100, 16'h0102, 1'b1, 16'h0100, 1'b1, 16'h0700, 1'b0);
        expect_const("resume_alloc", miss(16'h0100), miss(16'h0102), 1'b0);
        tick();
        idle(16'h0100, 16'h0102);
        expect_const("resume_hit", hit_tk(16'h0700), miss(16'h0102), 1'b0);
        tick();
        rst_n = 1'b0;
        expect_const("async_reset_clears_hit", miss(16'h0100), miss(16'h0102), 1'b0);
        tick();
        rst_n = 1'b1;

        // Randomised traffic against the model; a small PC pool forces hits and conflicts
        for (int n = 0; n < 700; n++) begin
            ra = {7'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 2)), 1'($urandom)};
            rb = {7'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 2)), 1'($urandom)};
            rp = {7'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 2)), 1'($urandom)};
            if ($urandom_range(0, 15) == 0) ra = 16'($urandom);
            drive(ra, rb, ($urandom_range(0, 3) != 0), rp, 1'($urandom),
                  16'($urandom), ($urandom_range(0, 249) == 0));
            expect_model($sformatf("rand_%0d", n));
            tick();
        end

        idle(16'h0000, 16'h0000);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
